// File: rtl/user_wb_mux.sv
// user_wb_mux: Wishbone fan-out from the Caravel management slave port to NUM_CH user slaves,
// with a CSR window, decode-error/timeout aborts and user_irq aggregation. Optional feature macro: USER_WB_MUX_TIMEOUT_EN.
module user_wb_mux #(
    parameter int          NUM_CH    = 4,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          WIN_BITS  = 16,
    parameter int          TIMEOUT   = 255
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_n_i,
    input  logic                   wbs_cyc_i,
    input  logic                   wbs_stb_i,
    input  logic                   wbs_we_i,
    input  logic [3:0]             wbs_sel_i,
    input  logic [31:0]            wbs_adr_i,
    input  logic [31:0]            wbs_dat_i,
    output logic                   wbs_ack_o,
    output logic [31:0]            wbs_dat_o,
    output logic [NUM_CH-1:0]      m_cyc_o,
    output logic [NUM_CH-1:0]      m_stb_o,
    output logic                   m_we_o,
    output logic [3:0]             m_sel_o,
    output logic [31:0]            m_adr_o,
    output logic [31:0]            m_dat_o,
    input  logic [NUM_CH*32-1:0]   m_dat_i,
    input  logic [NUM_CH-1:0]      m_ack_i,
    input  logic [NUM_CH-1:0]      ch_irq_i,
    output logic [2:0]             user_irq_o
);

    localparam logic [31:0]         DEAD_DATA = 32'hDEAD_BEEF;
    localparam logic [3:0]          CSR_IDX   = 4'hF;
    localparam logic [3:0]          NUM_CH_L  = 4'(NUM_CH);
    localparam logic [WIN_BITS-1:0] OFF_MASK  = WIN_BITS'(32'h0000_0000);
    localparam logic [WIN_BITS-1:0] OFF_STAT  = WIN_BITS'(32'h0000_0004);
    localparam logic [WIN_BITS-1:0] OFF_TO    = WIN_BITS'(32'h0000_0008);
    localparam logic [WIN_BITS-1:0] OFF_ERR   = WIN_BITS'(32'h0000_000C);

    if (NUM_CH < 1 || NUM_CH > 8 || TIMEOUT < 1 || TIMEOUT > 1023) begin : g_param_check
        $error("user_wb_mux: NUM_CH must be 1..8 and TIMEOUT 1..1023");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_s;

    logic                wbs_ack_r;
    logic [31:0]         wbs_dat_r;
    logic [NUM_CH-1:0]   m_stb_r;
    logic                m_we_r;
    logic [3:0]          m_sel_r;
    logic [31:0]         m_adr_r;
    logic [31:0]         m_dat_r;
    logic [2:0]          user_irq_r;

    logic [NUM_CH-1:0]   irq_mask_r;
    logic [NUM_CH-1:0]   irq_stat_r;
    logic                err_r;
    logic [NUM_CH-1:0]   to_stat_s;

    logic                req_s;
    logic                in_space_s;
    logic [3:0]          idx_s;
    logic                hit_ch_s;
    logic                hit_csr_s;
    logic [WIN_BITS-1:0] csr_off_s;
    logic [NUM_CH-1:0]   onehot_s;
    logic                ack_sel_s;
    logic [31:0]         ch_rdat_s;
    logic [31:0]         csr_rdat_s;

    logic                ack_s;
    logic [31:0]         dat_nx_s;
    logic [NUM_CH-1:0]   stb_s;
    logic                latch_s;
    logic                csr_acc_s;
    logic                err_set_s;

    logic                csr_wr_s;
    logic                mask_wr_s;
    logic [NUM_CH-1:0]   stat_w1c_s;
    logic                err_w1c_s;

    assign req_s      = wbs_cyc_i & wbs_stb_i;
    assign in_space_s = (wbs_adr_i[31:WIN_BITS+4] == BASE_ADDR[31:WIN_BITS+4]);
    assign idx_s      = wbs_adr_i[WIN_BITS+3:WIN_BITS];
    assign hit_ch_s   = in_space_s & (idx_s < NUM_CH_L);
    assign hit_csr_s  = in_space_s & (idx_s == CSR_IDX);
    assign csr_off_s  = wbs_adr_i[WIN_BITS-1:0];
    assign onehot_s   = NUM_CH'(1'b1) << idx_s;

    // The registered strobe doubles as the selected-channel one-hot while in WAIT.
    assign ack_sel_s  = |(m_ack_i & m_stb_r);

    // Read data of whichever channel currently holds the strobe
    always_comb begin
        ch_rdat_s = 32'h0000_0000;
        for (int k = 0; k < NUM_CH; k++) begin
            ch_rdat_s = ch_rdat_s | ({32{m_stb_r[k]}} & m_dat_i[32*k +: 32]);
        end
    end

`ifdef USER_WB_MUX_TIMEOUT_EN
    logic [9:0]        to_cnt_r;
    logic [NUM_CH-1:0] to_stat_r;
    logic              to_fire_s;
    logic [NUM_CH-1:0] to_set_s;
    logic [NUM_CH-1:0] to_w1c_s;

    assign to_fire_s = (to_cnt_r == 10'(TIMEOUT));
    assign to_stat_s = to_stat_r;
    assign to_w1c_s  = {NUM_CH{csr_wr_s & (csr_off_s == OFF_TO)}} & wbs_dat_i[NUM_CH-1:0];

    // Timeout counter: cleared on WAIT entry, counts WAIT cycles without an ack
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            to_cnt_r <= 10'd0;
        end else if (latch_s) begin
            to_cnt_r <= 10'd0;
        end else if ((state_r == ST_WAIT) && !ack_sel_s && !to_fire_s) begin
            to_cnt_r <= to_cnt_r + 10'd1;
        end
    end

    // Sticky per-channel timeout status; a new timeout wins over a same-cycle clear
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            to_stat_r <= {NUM_CH{1'b0}};
        end else begin
            to_stat_r <= (to_stat_r & ~to_w1c_s) | to_set_s;
        end
    end
`else
    assign to_stat_s = {NUM_CH{1'b0}};
`endif

    // Next-state and registered-output sources for the transfer FSM
    always_comb begin
        state_s   = state_r;
        ack_s     = 1'b0;
        dat_nx_s  = wbs_dat_r;
        stb_s     = m_stb_r;
        latch_s   = 1'b0;
        csr_acc_s = 1'b0;
        err_set_s = 1'b0;
`ifdef USER_WB_MUX_TIMEOUT_EN
        to_set_s  = {NUM_CH{1'b0}};
`endif
        case (state_r)
            ST_IDLE: begin
                if (req_s && hit_ch_s) begin
                    state_s = ST_WAIT;
                    stb_s   = onehot_s;
                    latch_s = 1'b1;
                end else if (req_s && hit_csr_s) begin
                    state_s   = ST_RESP;
                    ack_s     = 1'b1;
                    dat_nx_s  = csr_rdat_s;
                    csr_acc_s = 1'b1;
                end else if (req_s) begin
                    state_s   = ST_RESP;
                    ack_s     = 1'b1;
                    dat_nx_s  = DEAD_DATA;
                    err_set_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!wbs_cyc_i) begin
                    state_s = ST_IDLE;
                    stb_s   = {NUM_CH{1'b0}};
                end else if (ack_sel_s) begin
                    state_s  = ST_RESP;
                    ack_s    = 1'b1;
                    dat_nx_s = ch_rdat_s;
                    stb_s    = {NUM_CH{1'b0}};
`ifdef USER_WB_MUX_TIMEOUT_EN
                end else if (to_fire_s) begin
                    state_s  = ST_RESP;
                    ack_s    = 1'b1;
                    dat_nx_s = DEAD_DATA;
                    stb_s    = {NUM_CH{1'b0}};
                    to_set_s = m_stb_r;
`endif
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                stb_s   = {NUM_CH{1'b0}};
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Upstream response and downstream request registers
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            wbs_ack_r <= 1'b0;
            wbs_dat_r <= 32'h0000_0000;
            m_stb_r   <= {NUM_CH{1'b0}};
            m_we_r    <= 1'b0;
            m_sel_r   <= 4'h0;
            m_adr_r   <= 32'h0000_0000;
            m_dat_r   <= 32'h0000_0000;
        end else begin
            wbs_ack_r <= ack_s;
            wbs_dat_r <= dat_nx_s;
            m_stb_r   <= stb_s;
            if (latch_s) begin
                m_we_r  <= wbs_we_i;
                m_sel_r <= wbs_sel_i;
                m_adr_r <= wbs_adr_i;
                m_dat_r <= wbs_dat_i;
            end
        end
    end

    assign csr_wr_s   = csr_acc_s & wbs_we_i;
    assign mask_wr_s  = csr_wr_s & (csr_off_s == OFF_MASK);
    assign stat_w1c_s = {NUM_CH{csr_wr_s & (csr_off_s == OFF_STAT)}} & wbs_dat_i[NUM_CH-1:0];
    assign err_w1c_s  = csr_wr_s & (csr_off_s == OFF_ERR) & wbs_dat_i[0];

    // CSR read mux
    always_comb begin
        case (csr_off_s)
            OFF_MASK: csr_rdat_s = 32'(irq_mask_r);
            OFF_STAT: csr_rdat_s = 32'(irq_stat_r);
            OFF_TO:   csr_rdat_s = 32'(to_stat_s);
            OFF_ERR:  csr_rdat_s = {31'd0, err_r};
            default:  csr_rdat_s = 32'h0000_0000;
        endcase
    end

    // Mask, sticky interrupt/error status (set beats clear) and registered IRQ lines
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            irq_mask_r <= {NUM_CH{1'b0}};
            irq_stat_r <= {NUM_CH{1'b0}};
            err_r      <= 1'b0;
            user_irq_r <= 3'b000;
        end else begin
            if (mask_wr_s) begin
                irq_mask_r <= wbs_dat_i[NUM_CH-1:0];
            end
            irq_stat_r    <= (irq_stat_r & ~stat_w1c_s) | ch_irq_i;
            err_r         <= (err_r & ~err_w1c_s) | err_set_s;
            user_irq_r[0] <= |(irq_stat_r & irq_mask_r);
            user_irq_r[1] <= |to_stat_s;
            user_irq_r[2] <= err_r;
        end
    end

    assign wbs_ack_o  = wbs_ack_r;
    assign wbs_dat_o  = wbs_dat_r;
    assign m_cyc_o    = m_stb_r;
    assign m_stb_o    = m_stb_r;
    assign m_we_o     = m_we_r;
    assign m_sel_o    = m_sel_r;
    assign m_adr_o    = m_adr_r;
    assign m_dat_o    = m_dat_r;
    assign user_irq_o = user_irq_r;

endmodule

// File: tb/tb_user_wb_mux.sv
// Self-checking bench for user_wb_mux: directed scenarios plus randomized transfers
// checked against a transaction-level model of the address map and CSR status bits.
`timescale 1ns/1ps
module tb_user_wb_mux;

    localparam int          NUM_CH   = 4;
    localparam int          WIN_BITS = 16;
    localparam int          TIMEOUT  = 255;
    localparam logic [31:0] BASE     = 32'h3000_0000;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]           sel = 4'h0;
    logic [31:0]          adr = 32'h0, wdat = 32'h0;
    logic                 ack;
    logic [31:0]          rdat;
    logic [NUM_CH-1:0]    m_cyc, m_stb;
    logic                 m_we;
    logic [3:0]           m_sel;
    logic [31:0]          m_adr, m_dat;
    logic [NUM_CH*32-1:0] m_dat_in = '0;
    logic [NUM_CH-1:0]    m_ack = '0;
    logic [NUM_CH-1:0]    ch_irq = '0;
    logic [2:0]           user_irq;

    int checks = 0;
    int errors = 0;

    logic [NUM_CH-1:0] md_mask = '0, md_stat = '0, md_to = '0;
    logic              md_err = 1'b0;
    logic [31:0]       offs [6] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h100};

    user_wb_mux #(.NUM_CH(NUM_CH), .BASE_ADDR(BASE), .WIN_BITS(WIN_BITS), .TIMEOUT(TIMEOUT)) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
        .m_cyc_o(m_cyc), .m_stb_o(m_stb), .m_we_o(m_we), .m_sel_o(m_sel),
        .m_adr_o(m_adr), .m_dat_o(m_dat), .m_dat_i(m_dat_in), .m_ack_i(m_ack),
        .ch_irq_i(ch_irq), .user_irq_o(user_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock edge; the model absorbs what the edge samples (reset, level interrupts).
    task automatic tick();
        if (!rst_n) begin
            md_mask = '0; md_stat = '0; md_to = '0; md_err = 1'b0;
        end else begin
            md_stat = md_stat | ch_irq;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_irq(input string tag);
        tick();
        tick();
        chk(tag, 32'(user_irq), 32'({md_err, |md_to, |(md_stat & md_mask)}));
    endtask

    // Full transfer: d = cycles between strobe and slave ack, srd = slave read data.
    task automatic do_txn(input logic [31:0] a, input logic w, input logic [31:0] wd,
                          input logic [3:0] s, input int d, input logic [31:0] srd, input string tag);
        bit in_sp, got;
        int idx, off, kind, n;
        logic [31:0] exp_rd;
        logic [NUM_CH-1:0] exp_oh;
        in_sp  = ((a >> (WIN_BITS + 4)) == (BASE >> (WIN_BITS + 4)));
        idx    = int'((a >> WIN_BITS) & 32'h0000_000F);
        off    = int'(a & ((32'h1 << WIN_BITS) - 32'h1));
        exp_oh = '0;
        exp_rd = 32'hDEAD_BEEF;
        if (in_sp && idx < NUM_CH) begin
            kind = 0;
            exp_oh[idx] = 1'b1;
            exp_rd = srd;
        end else if (in_sp && idx == 15) begin
            kind = 1;
            case (off)
                0:  exp_rd = 32'(md_mask);
                4:  exp_rd = 32'(md_stat);
                8:  exp_rd = 32'(md_to);
                12: exp_rd = 32'(md_err);
                default: exp_rd = 32'h0;
            endcase
            if (w) begin
                case (off)
                    0:  md_mask = wd[NUM_CH-1:0];
                    4:  md_stat = md_stat & ~wd[NUM_CH-1:0];
                    8:  md_to   = md_to & ~wd[NUM_CH-1:0];
                    12: md_err  = md_err & ~wd[0];
                    default: ;
                endcase
            end
        end else begin
            kind = 2;
            md_err = 1'b1;
        end
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = wd; sel = s; m_ack = '0;
        n = 0;
        got = 1'b0;
        while (!got && n < 64) begin
            tick();
            n++;
            if (ack) begin
                got = 1'b1;
            end else begin
                if (n == 1) begin
                    chk({tag, ":stb"}, 32'(m_stb), 32'(exp_oh));
                    chk({tag, ":cyc"}, 32'(m_cyc), 32'(exp_oh));
                    if (kind == 0) begin
                        chk({tag, ":m_adr"}, m_adr, a);
                        chk({tag, ":m_we"}, 32'(m_we), 32'(w));
                        chk({tag, ":m_dat"}, m_dat, wd);
                        chk({tag, ":m_sel"}, 32'(m_sel), 32'(s));
                    end
                end
                for (int k = 0; k < NUM_CH; k++) m_dat_in[32*k +: 32] = $urandom;
                if (kind == 0 && n == d + 1) begin
                    m_ack = exp_oh;
                    m_dat_in[32*idx +: 32] = srd;
                end else begin
                    m_ack = NUM_CH'($urandom) & ~exp_oh;
                end
            end
        end
        chk({tag, ":latency"}, got ? n : 0, (kind == 0) ? d + 2 : 1);
        if (!w) chk({tag, ":rdata"}, rdat, exp_rd);
        chk({tag, ":stb_at_ack"}, 32'(m_stb), 32'h0);
        cyc = 1'b0; stb = 1'b0; m_ack = '0;
        tick();
        chk({tag, ":ack_one_cycle"}, 32'(ack), 32'h0);
    endtask

    initial begin
        int n, acks;
        logic [31:0] a;
        // reset state
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst:ack", 32'(ack), 32'h0);
        chk("rst:rdat", rdat, 32'h0);
        chk("rst:stb", 32'(m_stb), 32'h0);
        chk("rst:cyc", 32'(m_cyc), 32'h0);
        chk("rst:req", {m_we, m_sel, 27'd0}, 32'h0);
        chk("rst:adr", m_adr, 32'h0);
        chk("rst:dat", m_dat, 32'h0);
        chk("rst:irq", 32'(user_irq), 32'h0);
        rst_n = 1'b1;
        tick();

        do_txn(32'h3001_0004, 1'b1, 32'h1234_5678, 4'hF, 0, 32'h0, "wr_ch1");
        do_txn(32'h3000_0000, 1'b0, 32'h0, 4'hF, 3, 32'hCAFE_F00D, "rd_ch0_late");

        // channel 2 never acks
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3002_0000; sel = 4'hF; m_ack = '0;
`ifdef USER_WB_MUX_TIMEOUT_EN
        n = 0;
        while (!ack && n < 400) begin
            tick();
            n++;
        end
        chk("timeout:latency", n, TIMEOUT + 2);
        chk("timeout:rdata", rdat, 32'hDEAD_BEEF);
        chk("timeout:stb", 32'(m_stb), 32'h0);
        md_to = md_to | 4'b0100;
        cyc = 1'b0; stb = 1'b0;
        tick();
        do_txn(32'h300F_0008, 1'b0, 32'h0, 4'hF, 0, 32'h0, "rd_to_stat");
        chk_irq("timeout:irq");
        do_txn(32'h300F_0008, 1'b1, 32'h0000_0004, 4'hF, 0, 32'h0, "w1c_to_stat");
        chk_irq("timeout_clr:irq");
`else
        acks = 0;
        repeat (1000) begin
            tick();
            if (ack) acks++;
        end
        chk("no_timeout:acks", acks, 0);
        chk("no_timeout:stb_held", 32'(m_stb), 32'h4);
        cyc = 1'b0; stb = 1'b0;
        tick();
        chk("no_timeout:abort_stb", 32'(m_stb), 32'h0);
        chk("no_timeout:abort_ack", 32'(ack), 32'h0);
        do_txn(32'h300F_0008, 1'b0, 32'h0, 4'hF, 0, 32'h0, "rd_to_stat");
        chk_irq("no_timeout:irq");
`endif

        // decode error and ERR clear
        do_txn(32'h3005_0000, 1'b0, 32'h0, 4'hF, 0, 32'h0, "decode_err");
        chk_irq("decode_err:irq");
        do_txn(32'h300F_000C, 1'b1, 32'h0000_0001, 4'hF, 0, 32'h0, "w1c_err");
        chk_irq("err_clr:irq");

        // masked channel interrupt, W1C while the source is still high
        do_txn(32'h300F_0000, 1'b1, 32'h0000_0008, 4'hF, 0, 32'h0, "wr_mask");
        ch_irq = 4'b1000;
        chk_irq("ch3:irq");
        do_txn(32'h300F_0004, 1'b1, 32'h0000_000F, 4'hF, 0, 32'h0, "w1c_stat_busy");
        do_txn(32'h300F_0004, 1'b0, 32'h0, 4'hF, 0, 32'h0, "rd_stat_sticky");
        chk("stat_sticky:direct", rdat, 32'h8);
        ch_irq = 4'b0000;
        do_txn(32'h300F_0004, 1'b1, 32'h0000_000F, 4'hF, 0, 32'h0, "w1c_stat_idle");
        do_txn(32'h300F_0004, 1'b0, 32'h0, 4'hF, 0, 32'h0, "rd_stat_clr");
        chk_irq("ch3_clr:irq");

        // master abort in WAIT
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3001_0000; m_ack = '0;
        tick();
        chk("abort:stb_up", 32'(m_stb), 32'h2);
        tick();
        cyc = 1'b0; stb = 1'b0;
        tick();
        chk("abort:stb", 32'(m_stb), 32'h0);
        chk("abort:ack", 32'(ack), 32'h0);
        tick();
        chk("abort:ack_late", 32'(ack), 32'h0);
        do_txn(32'h3003_0010, 1'b0, 32'h0, 4'hF, 1, 32'h5A5A_A5A5, "after_abort");

        // reset in WAIT
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3003_0000; wdat = 32'h1;
        tick();
        chk("rst_wait:stb_up", 32'(m_stb), 32'h8);
        rst_n = 1'b0;
        tick();
        chk("rst_wait:stb", 32'(m_stb), 32'h0);
        chk("rst_wait:ack", 32'(ack), 32'h0);
        rst_n = 1'b1;
        cyc = 1'b0; stb = 1'b0;
        tick();
        chk("rst_wait:ack_late", 32'(ack), 32'h0);
        do_txn(32'h3002_0020, 1'b0, 32'h0, 4'hF, 2, 32'h0BAD_F00D, "after_rst");

        // randomized traffic
        for (int t = 0; t < 160; t++) begin
            int pick;
            pick = $urandom_range(0, 5);
            if (t % 8 == 0) ch_irq = NUM_CH'($urandom);
            case (pick)
                0, 1, 2: a = BASE | (32'($urandom_range(0, NUM_CH - 1)) << WIN_BITS) | ($urandom & 32'h0000_FFFC);
                3, 4:    a = BASE | (32'hF << WIN_BITS) | offs[$urandom_range(0, 5)];
                default: begin
                    if ($urandom_range(0, 1) == 1)
                        a = BASE | (32'($urandom_range(NUM_CH, 14)) << WIN_BITS) | ($urandom & 32'h0000_FFFC);
                    else
                        a = (BASE ^ (32'h1 << $urandom_range(WIN_BITS + 4, 31))) | ($urandom & 32'h000F_FFFC);
                end
            endcase
            do_txn(a, 1'($urandom), $urandom, 4'($urandom), $urandom_range(0, 4), $urandom, "rand");
            if (t % 10 == 9) chk_irq("rand:irq");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
